touch_responder: RTL

SPI-style slave that emulates the touch-panel ADC on the far end of the touch-controller serial link, for bench and loop-back use on the board. It oversamples the master's `dclk`/`cs`/`din` in the system clock domain and decodes an 8-bit LSB-first command: `0xDB` selects X, `0xD9` selects Y. It then returns the selected 8-bit coordinate MSB-first on `dout` over the next 8 `dclk` periods. Coordinates come from `x_val`/`y_val`, which are driven by a pattern generator or switches.

---
 rtl/touch_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/touch_responder.sv
// Touch-panel ADC emulator: SPI-style slave answering X/Y coordinate commands.
// Define TOUCH_PENIRQ_EN to add the touch input and active-low penirq output.
`timescale 1ns/1ps
module touch_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_X       = 8'hDB,
  parameter logic [7:0]  CMD_Y       = 8'hD9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dclk,
  input  logic       cs,
  input  logic       din,
  output logic       dout,
  output logic       busy,
  input  logic [7:0] x_val,
  input  logic [7:0] y_val,
  output logic       frame_done,
  output logic       cmd_err
`ifdef TOUCH_PENIRQ_EN
  ,
  input  logic       touch,
  output logic       penirq
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    CONV = 2'd2,
    RESP = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] dclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] din_sync_r;
  logic                   dclk_d_r;
  logic                   cs_d_r;

  logic dclk_s;
  logic cs_s;
  logic din_s;
  logic rise_s;
  logic fall_s;
  logic cs_fall_s;

  state_t     state_r;
  logic [2:0] cnt_r;
  logic [6:0] cmd_sr_r;
  logic [7:0] cmd_next_s;
  logic [7:0] resp_r;
  logic       dout_r;
  logic       busy_r;
  logic       frame_done_r;
  logic       cmd_err_r;

  assign dclk_s     = dclk_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign din_s      = din_sync_r[SYNC_STAGES-1];
  assign rise_s     = dclk_s & ~dclk_d_r;
  assign fall_s     = ~dclk_s & dclk_d_r;
  assign cs_fall_s  = ~cs_s & cs_d_r;
  // The eighth command bit is decoded straight from the synced din.
  assign cmd_next_s = {din_s, cmd_sr_r};

  assign dout       = dout_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign cmd_err    = cmd_err_r;

  // Synchronizers for the master's asynchronous lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b0}};
      din_sync_r  <= {SYNC_STAGES{1'b0}};
    end else begin
      dclk_sync_r <= {dclk_sync_r[SYNC_STAGES-2:0], dclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Delayed copies for edge strobes; cs resets low so a held-low cs is not seen as a fresh select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dclk_d_r <= 1'b0;
      cs_d_r   <= 1'b0;
    end else begin
      dclk_d_r <= dclk_s;
      cs_d_r   <= cs_s;
    end
  end

  // Frame state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      cmd_sr_r     <= 7'd0;
      resp_r       <= 8'd0;
      dout_r       <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      cmd_err_r    <= 1'b0;
      if (cs_s) begin
        state_r  <= IDLE;
        cnt_r    <= 3'd0;
        cmd_sr_r <= 7'd0;
        resp_r   <= 8'd0;
        dout_r   <= 1'b0;
        busy_r   <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            dout_r <= 1'b0;
            cnt_r  <= 3'd0;
            if (cs_fall_s) begin
              state_r <= CMD;
            end
          end
          CMD: begin
            if (rise_s) begin
              cmd_sr_r <= cmd_next_s[7:1];
              cnt_r    <= cnt_r + 3'd1;
              if (cnt_r == 3'd7) begin
                case (cmd_next_s)
                  CMD_X:   resp_r <= x_val;
                  CMD_Y:   resp_r <= y_val;
                  default: begin
                    resp_r    <= 8'd0;
                    cmd_err_r <= 1'b1;
                  end
                endcase
                busy_r  <= 1'b1;
                state_r <= CONV;
              end
            end
          end
          CONV: begin
            if (fall_s) begin
              dout_r  <= resp_r[7];
              busy_r  <= 1'b0;
              cnt_r   <= 3'd1;
              state_r <= RESP;
            end
          end
          RESP: begin
            if (fall_s) begin
              // Counter back at 0 means bit 0 has been held a full period.
              if (cnt_r == 3'd0) begin
                dout_r       <= 1'b0;
                frame_done_r <= 1'b1;
                state_r      <= CMD;
              end else begin
                resp_r <= {resp_r[6:0], 1'b0};
                dout_r <= resp_r[6];
                cnt_r  <= cnt_r + 3'd1;
              end
            end
          end
          default: begin
            state_r <= IDLE;
            dout_r  <= 1'b0;
            busy_r  <= 1'b0;
            cnt_r   <= 3'd0;
          end
        endcase
      end
    end
  end

`ifdef TOUCH_PENIRQ_EN
  logic penirq_r;
  assign penirq = penirq_r;

  // Pen-down interrupt, only reported while no frame is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      penirq_r <= 1'b1;
    end else begin
      penirq_r <= ~(touch & (state_r == IDLE));
    end
  end
`endif

endmodule
